dual_port_ram_be: RTL and testbench

//  Simple dual-port synchronous RAM (1 write port, 1 read port, one clock) with per-byte write enables.

---
 rtl/dual_port_ram_be.sv | 234 +++++++++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, 1- or
// 2-cycle read latency, selectable read-during-write behaviour, a post-reset
// clear sequencer and a sticky out-of-range flag.
// Optional feature macro: DPRAM_COLL_CNT_EN adds the COLL_CNT collision counter.
module dual_port_ram_be #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    RD_LATENCY = 1,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN_WR,
  input  logic [DATA_WIDTH/8-1:0] BE_WR,
  input  logic [ADDR_WIDTH-1:0]   ADDR_WR,
  input  logic [DATA_WIDTH-1:0]   D_IN,
  input  logic                    EN_RD,
  input  logic [ADDR_WIDTH-1:0]   ADDR_RD,
  output logic [DATA_WIDTH-1:0]   D_OUT,
  output logic                    VALID_OUT,
  output logic                    BUSY,
  output logic                    OOR_ERR
`ifdef DPRAM_COLL_CNT_EN
  ,
  output logic [15:0]             COLL_CNT
`endif
);

  localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Merge enabled byte lanes of the new word over the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idle;
  logic                    wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0]   wr_idx, rd_idx;
  logic                    wr_acc, rd_req, collision;
  logic [DATA_WIDTH-1:0]   old_word, merged_word, rd_word;
  logic                    oor_q;

  // Clear-sequencer state and pointer register; reset restarts the clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: walk the pointer through every word, then go idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = RST_N;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign BUSY = (state_q == ST_CLEAR);
  assign idle = (state_q == ST_IDLE) && RST_N;

  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past DEPTH; their effects are masked by the in-range flags.
  assign wr_in_range = ({1'b0, ADDR_WR} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, ADDR_RD} < DEPTH_LIM);
  assign wr_idx      = wr_in_range ? ADDR_WR : '0;
  assign rd_idx      = rd_in_range ? ADDR_RD : '0;

  assign wr_acc    = idle && EN_WR && wr_in_range;
  assign rd_req    = idle && EN_RD;
  assign collision = wr_acc && rd_req && rd_in_range && (ADDR_WR == ADDR_RD);

  assign old_word    = mem[rd_idx];
  assign merged_word = merge_bytes(old_word, D_IN, BE_WR);

  // Write-through only when configured; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = (collision && (RDW_MODE == 1)) ? merged_word : old_word;
    end
  end

  // Storage array: clear-sequencer writes take priority over user writes.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[ptr_q] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (BE_WR[i]) begin
          mem[wr_idx][8*i +: 8] <= D_IN[8*i +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_data_p0;
      logic                  vld_p0;
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // Stage p0: capture array word at the accept edge.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          vld_p0 <= 1'b0;
        end else begin
          vld_p0 <= rd_req;
        end
      end

      // Stage p0 data: loaded only on accepted reads.
      always_ff @(posedge CLK) begin
        if (rd_req) begin
          rd_data_p0 <= rd_word;
        end
      end

      // Stage p1: output register, holds value when no read completes.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          vld_p1     <= 1'b0;
          rd_data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            rd_data_p1 <= rd_data_p0;
          end
        end
      end

      assign D_OUT     = rd_data_p1;
      assign VALID_OUT = vld_p1;
    end else begin : g_lat1
      logic [DATA_WIDTH-1:0] rd_data_p0;
      logic                  vld_p0;

      // Stage p0: output register loaded at the accept edge, held otherwise.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          vld_p0     <= 1'b0;
          rd_data_p0 <= '0;
        end else begin
          vld_p0 <= rd_req;
          if (rd_req) begin
            rd_data_p0 <= rd_word;
          end
        end
      end

      assign D_OUT     = rd_data_p0;
      assign VALID_OUT = vld_p0;
    end
  endgenerate

  // Sticky out-of-range flag, set only by requests seen while idle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      oor_q <= 1'b0;
    end else if (idle && ((EN_WR && !wr_in_range) || (EN_RD && !rd_in_range))) begin
      oor_q <= 1'b1;
    end
  end

  assign OOR_ERR = oor_q;

`ifdef DPRAM_COLL_CNT_EN
  logic [15:0] coll_cnt_q;

  // Saturating count of same-address read/write collisions.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      coll_cnt_q <= '0;
    end else if (collision) begin
      coll_cnt_q <= sat_inc16(coll_cnt_q);
    end
  end

  assign COLL_CNT = coll_cnt_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: instance 0 uses defaults
// (latency 1, old-data collisions, depth 16); instance 1 uses latency 2,
// write-through collisions and depth 12.
module tb_dual_port_ram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        en_wr     [2];
  logic [1:0]  be_wr     [2];
  logic [3:0]  addr_wr   [2];
  logic [15:0] d_in      [2];
  logic        en_rd     [2];
  logic [3:0]  addr_rd   [2];
  logic [15:0] d_out     [2];
  logic        valid_out [2];
  logic        busy      [2];
  logic        oor_err   [2];
`ifdef DPRAM_COLL_CNT_EN
  logic [15:0] coll_cnt  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dual_port_ram_be #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16),
    .RD_LATENCY(1), .RDW_MODE(0), .INIT_VAL(16'h0000)
  ) u_dut0 (
    .CLK(clk), .RST_N(rst_n[0]),
    .EN_WR(en_wr[0]), .BE_WR(be_wr[0]), .ADDR_WR(addr_wr[0]), .D_IN(d_in[0]),
    .EN_RD(en_rd[0]), .ADDR_RD(addr_rd[0]),
    .D_OUT(d_out[0]), .VALID_OUT(valid_out[0]), .BUSY(busy[0]), .OOR_ERR(oor_err[0])
`ifdef DPRAM_COLL_CNT_EN
    , .COLL_CNT(coll_cnt[0])
`endif
  );

  dual_port_ram_be #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12),
    .RD_LATENCY(2), .RDW_MODE(1), .INIT_VAL(16'h0000)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst_n[1]),
    .EN_WR(en_wr[1]), .BE_WR(be_wr[1]), .ADDR_WR(addr_wr[1]), .D_IN(d_in[1]),
    .EN_RD(en_rd[1]), .ADDR_RD(addr_rd[1]),
    .D_OUT(d_out[1]), .VALID_OUT(valid_out[1]), .BUSY(busy[1]), .OOR_ERR(oor_err[1])
`ifdef DPRAM_COLL_CNT_EN
    , .COLL_CNT(coll_cnt[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic [15:0] v, input logic [1:0] be);
    en_wr[d] = 1'b1; addr_wr[d] = a; d_in[d] = v; be_wr[d] = be;
    tick();
    en_wr[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [3:0] a);
    en_rd[d] = 1'b1; addr_rd[d] = a;
    tick();
    en_rd[d] = 1'b0;
  endtask

  task automatic wrrd(input int d, input logic [3:0] wa, input logic [15:0] v,
                      input logic [1:0] be, input logic [3:0] ra);
    en_wr[d] = 1'b1; addr_wr[d] = wa; d_in[d] = v; be_wr[d] = be;
    en_rd[d] = 1'b1; addr_rd[d] = ra;
    tick();
    en_wr[d] = 1'b0;
    en_rd[d] = 1'b0;
  endtask

  initial begin
    int nb0, nb1, nv;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; en_wr[d] = 1'b0; be_wr[d] = 2'b00; addr_wr[d] = 4'd0;
      d_in[d] = 16'h0000; en_rd[d] = 1'b0; addr_rd[d] = 4'd0;
    end

    // Reset for three cycles, then both instances clear their arrays.
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_dout%0d", d),  d_out[d],     16'h0000);
      check($sformatf("rst_valid%0d", d), valid_out[d], 1'b0);
      check($sformatf("rst_oor%0d", d),   oor_err[d],   1'b0);
      check($sformatf("rst_busy%0d", d),  busy[d],      1'b1);
`ifdef DPRAM_COLL_CNT_EN
      check($sformatf("rst_coll%0d", d),  coll_cnt[d],  16'd0);
`endif
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    nb0 = 0; nb1 = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy[0]) nb0++;
      if (busy[1]) nb1++;
      tick();
    end
    check("busy_len0", nb0, 16);
    check("busy_len1", nb1, 12);

    // Back-to-back readback of the cleared array (latency 1).
    for (int a = 0; a < 16; a++) begin
      en_rd[0] = 1'b1; addr_rd[0] = a[3:0];
      tick();
      check($sformatf("clr_valid_a%0d", a), valid_out[0], 1'b1);
      check($sformatf("clr_data_a%0d", a),  d_out[0],     16'h0000);
    end
    en_rd[0] = 1'b0;
    tick();
    check("clr_valid_end", valid_out[0], 1'b0);

    // Byte-lane writes.
    wr(0, 4'd3, 16'hA5C3, 2'b11);
    wr(0, 4'd3, 16'hFF00, 2'b01);
    rd(0, 4'd3);
    check("be_valid", valid_out[0], 1'b1);
    check("be_data",  d_out[0],     16'hA500);
    tick();
    check("be_hold_valid", valid_out[0], 1'b0);
    check("be_hold_data",  d_out[0],     16'hA500);

    // Collision on instance 0 returns the old word.
    wr(0, 4'd5, 16'h1234, 2'b11);
    wrrd(0, 4'd5, 16'hABCD, 2'b10, 4'd5);
    check("coll_old_valid", valid_out[0], 1'b1);
    check("coll_old_data",  d_out[0],     16'h1234);
    rd(0, 4'd5);
    check("coll_old_after", d_out[0], 16'hAB34);
    check("oor0_clean", oor_err[0], 1'b0);
`ifdef DPRAM_COLL_CNT_EN
    check("coll_cnt0", coll_cnt[0], 16'd1);
`endif

    // Latency 2: three pipelined reads.
    wr(1, 4'd1, 16'h1111, 2'b11);
    wr(1, 4'd2, 16'h2222, 2'b11);
    wr(1, 4'd3, 16'h3333, 2'b11);
    en_rd[1] = 1'b1; addr_rd[1] = 4'd1;
    tick();
    check("lat2_n1_valid", valid_out[1], 1'b0);
    addr_rd[1] = 4'd2;
    tick();
    check("lat2_n2_valid", valid_out[1], 1'b1);
    check("lat2_n2_data",  d_out[1],     16'h1111);
    addr_rd[1] = 4'd3;
    tick();
    en_rd[1] = 1'b0;
    check("lat2_n3_valid", valid_out[1], 1'b1);
    check("lat2_n3_data",  d_out[1],     16'h2222);
    tick();
    check("lat2_n4_valid", valid_out[1], 1'b1);
    check("lat2_n4_data",  d_out[1],     16'h3333);
    tick();
    check("lat2_hold_valid", valid_out[1], 1'b0);
    check("lat2_hold_data",  d_out[1],     16'h3333);

    // Write-through collisions on instance 1.
    wr(1, 4'd5, 16'h1234, 2'b11);
    wrrd(1, 4'd5, 16'hABCD, 2'b10, 4'd5);
    tick();
    check("wt_c1_valid", valid_out[1], 1'b1);
    check("wt_c1_data",  d_out[1],     16'hAB34);
    rd(1, 4'd5);
    tick();
    check("wt_after_data", d_out[1], 16'hAB34);
    wrrd(1, 4'd6, 16'hCAFE, 2'b01, 4'd6);
    tick();
    check("wt_c2_data", d_out[1], 16'h00FE);
    wrrd(1, 4'd6, 16'h1200, 2'b10, 4'd6);
    tick();
    check("wt_c3_data", d_out[1], 16'h12FE);
    wrrd(1, 4'd7, 16'h7777, 2'b11, 4'd6);
    tick();
    check("indep_rd_data", d_out[1], 16'h12FE);
    rd(1, 4'd7);
    tick();
    check("indep_wr_data", d_out[1], 16'h7777);
`ifdef DPRAM_COLL_CNT_EN
    check("coll_cnt1", coll_cnt[1], 16'd3);
`endif

    // Out-of-range accesses on the depth-12 instance.
    check("oor1_before", oor_err[1], 1'b0);
    wr(1, 4'd13, 16'h5555, 2'b11);
    check("oor1_set_wr", oor_err[1], 1'b1);
    rd(1, 4'd1);
    tick();
    check("oor_no_alias", d_out[1], 16'h1111);
    rd(1, 4'd13);
    tick();
    check("oor_rd_valid", valid_out[1], 1'b1);
    check("oor_rd_data",  d_out[1],     16'h0000);
    repeat (3) tick();
    check("oor1_sticky", oor_err[1], 1'b1);

    // Reset in the middle of the clear sequence restarts it.
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    repeat (6) tick();
    check("busy_mid", busy[0], 1'b1);
    rst_n[0] = 1'b0;
    tick();
    check("rst2_dout",  d_out[0],     16'h0000);
    check("rst2_valid", valid_out[0], 1'b0);
`ifdef DPRAM_COLL_CNT_EN
    check("rst2_coll", coll_cnt[0], 16'd0);
`endif
    rst_n[0] = 1'b1;
    nb0 = 0; nv = 0;
    for (int c = 0; c < 40; c++) begin
      en_wr[0] = busy[0]; addr_wr[0] = 4'd0; d_in[0] = 16'hBEEF; be_wr[0] = 2'b11;
      en_rd[0] = busy[0]; addr_rd[0] = 4'd0;
      if (busy[0]) nb0++;
      tick();
      if (valid_out[0]) nv++;
    end
    en_wr[0] = 1'b0;
    en_rd[0] = 1'b0;
    check("busy_restart_len", nb0, 16);
    check("busy_no_valid",    nv,  0);
    rd(0, 4'd0);
    check("busy_drop_valid", valid_out[0], 1'b1);
    check("busy_drop_data",  d_out[0],     16'h0000);
    check("oor0_after_rst",  oor_err[0],   1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
